// File: rtl/uart_pkg.sv
// uart_pkg
// Types and default parameters shared by the UART receive and transmit paths.
// No ports; imported by uart_rx_if, uart_sync and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int UART_N            = 8;
    localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Bundles the serial line and the received-word outputs of uart_rx.
//   rx          serial line, idles high
//   rx_data     {parity_bit, data[N-1:0]}, data[0] is the first bit on the line
//   rx_valid    one-cycle strobe per completed frame
//   parity_err  even-parity mismatch of the last frame
//   frame_err   stop bit was low in the last frame
//   busy        receiver is inside a frame
// Modports: master = line driver / word consumer side, slave = uart_rx.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int N = UART_N
) ();

    logic         rx;
    logic [N:0]   rx_data;
    logic         rx_valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync
// Two-flop synchroniser for a single asynchronous input.
//   clk    system clock
//   rst_n  asynchronous active-low reset; both flops load RST_VAL
//   d      asynchronous input
//   q      synchronised output, two cycles behind d
module uart_sync
    import uart_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART receiver: 8N1 by default, 8E1 when UART_PARITY_EN is defined.
// Samples each bit at its midpoint using a down-counter reloaded per bit.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.slave: rx in; rx_data, rx_valid, parity_err,
//          frame_err, busy out
// Build option: UART_PARITY_EN adds an even-parity bit between data and stop;
// without it rx_data[N] and parity_err are tied to 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N            = UART_N,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int            CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int            BIT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    uart_rx_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [N-1:0]      shift_q, shift_d;
    logic              rx_s;
    logic              prev_q;
    logic              tick;
    logic              strobe;

    logic [N:0]        data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;

`ifdef UART_PARITY_EN
    logic              pbit_q, pbit_d;
`endif

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    assign tick = (cnt_q == '0);

    // prev_q always tracks the line so a break (line held low after a
    // frame) cannot look like a new falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
`ifdef UART_PARITY_EN
            pbit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= rx_s;
`ifdef UART_PARITY_EN
            pbit_q  <= pbit_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        strobe  = 1'b0;
`ifdef UART_PARITY_EN
        pbit_d  = pbit_q;
`endif
        case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[N-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef UART_PARITY_EN
                    pbit_d = rx_s;
`endif
                    cnt_d   = CNT_FULL;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    strobe  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers load only on the strobe and hold until the next one;
    // the stop bit is still visible on rx_s in the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= strobe;
            if (strobe) begin
                ferr_q <= ~rx_s;
`ifdef UART_PARITY_EN
                data_q <= {pbit_q, shift_q};
                perr_q <= ^{pbit_q, shift_q};
`else
                data_q <= {1'b0, shift_q};
                perr_q <= 1'b0;
`endif
            end
        end
    end

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Randomised and directed frames for uart_rx; a queue-based scoreboard holds
// the expected word, flags and strobe cycle of every frame sent.
module tb_uart_rx;

    localparam int N   = 8;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT   = 2 + CPB / 2 + (N + P + 1) * CPB;
    localparam int FRAME = (N + P + 2) * CPB;

    typedef struct {
        logic [N:0] data;
        logic       perr;
        logic       ferr;
        longint     cyc;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc;
    int     checks;
    int     errors;
    int     busy_cycles;
    exp_t   exp_q[$];
    longint strobe_cyc[$];

    uart_rx_if #(.N(N)) bus ();

    uart_rx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.busy) busy_cycles++;
        if (rst_n && bus.rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_data", bus.rx_data, e.data);
                chk("parity_err", bus.parity_err, e.perr);
                chk("frame_err", bus.frame_err, e.ferr);
                chk("strobe_cycle", cyc, e.cyc);
                strobe_cyc.push_back(cyc);
            end
        end
    end

    // Drive rx for n cycles; always entered and left just after a rising edge.
    task automatic hold(input logic b, input int n);
        bus.rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic pb, input logic sb);
        exp_t e;
        e.data = {(P == 1) ? pb : 1'b0, d};
        e.perr = (P == 1) ? ((^d) ^ pb) : 1'b0;
        e.ferr = ~sb;
        e.cyc  = cyc + 1 + LAT;
        exp_q.push_back(e);
        hold(1'b0, CPB);
        for (int i = 0; i < N; i++) hold(d[i], CPB);
        if (P == 1) hold(pb, CPB);
        hold(sb, CPB);
    endtask

    initial begin
        int n0;
        int waited;
        checks = 0;
        errors = 0;
        busy_cycles = 0;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data", bus.rx_data, 0);
        chk("reset_rx_valid", bus.rx_valid, 0);
        chk("reset_parity_err", bus.parity_err, 0);
        chk("reset_frame_err", bus.frame_err, 0);
        chk("reset_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, 5);

        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, 10);
        send_frame(8'hA5, 1'b1, 1'b1);
        hold(1'b1, 10);

        // Stop bit low, then the line stays low (break): no retrigger.
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 3 * FRAME);
        chk("hold_rx_data", bus.rx_data, {1'b0, 8'h3C});
        chk("hold_frame_err", bus.frame_err, 1);
        hold(1'b1, 20);

        // Short low glitch: false start, back to idle after half a bit.
        busy_cycles = 0;
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        chk("glitch_busy_ok", (busy_cycles >= CPB / 2 - 1 && busy_cycles <= CPB / 2 + 1), 1);
        chk("glitch_idle", bus.busy, 0);

        n0 = strobe_cyc.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        hold(1'b1, 10);
        chk("b2b_count", strobe_cyc.size() - n0, 2);
        if (strobe_cyc.size() - n0 == 2)
            chk("b2b_spacing", strobe_cyc[n0 + 1] - strobe_cyc[n0], FRAME);

        for (int k = 0; k < 10; k++) begin
            logic [N-1:0] d;
            logic pb, sb;
            d  = N'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(d, pb, sb);
            hold(1'b1, sb ? $urandom_range(0, 20) : $urandom_range(1, 20));
        end

        send_frame(8'hC3, 1'b0, 1'b1);
        hold(1'b1, 10);

        // Abort mid-DATA with reset; the partial frame must leave no trace.
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB / 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_parity_err", bus.parity_err, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hold(1'b1, 5);
        send_frame(8'h5A, 1'b0, 1'b1);
        hold(1'b1, 10);

        waited = 0;
        while (exp_q.size() != 0 && waited < 1000) begin
            @(posedge clk);
            waited++;
        end
        chk("pending_frames", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
